// File: rtl/npu_instr_feeder.sv
// Instruction-memory front end for the NPU: loads a program, then serves fetches with one-cycle latency.
// Optional fetch counter enabled by defining FEEDER_FETCH_COUNT_EN.
module npu_instr_feeder #(
   parameter int INSTR_WIDTH  = 48,
   parameter int AWIDTH       = 10,
   parameter int DEPTH        = 1024,
   parameter int OPCODE_WIDTH = 4,
   parameter int END_OPCODE   = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   load_last,
   input  logic                   clear,
   input  logic                   start,
   input  logic                   get_instr,
   input  logic [AWIDTH-1:0]      get_instr_addr,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   busy,
   output logic                   done,
   output logic [AWIDTH:0]        prog_len,
   output logic                   load_overflow
`ifdef FEEDER_FETCH_COUNT_EN
   ,
   output logic [15:0]            fetch_count
`endif
);

   localparam logic [OPCODE_WIDTH-1:0] END_OP   = OPCODE_WIDTH'(END_OPCODE);
   localparam logic [INSTR_WIDTH-1:0]  NOP_WORD = {END_OP, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};
   localparam logic [AWIDTH:0]         ONE      = (AWIDTH+1)'(1);
   localparam logic [AWIDTH:0]         LAST_PTR = (AWIDTH+1)'(DEPTH-1);
   localparam logic [AWIDTH:0]         FULL_LEN = (AWIDTH+1)'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Selects what the instruction bus shows; the RAM read register itself carries no reset.
   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_RAM  = 2'd1,
      SEL_NOP  = 2'd2
   } sel_t;

   state_t                 state_r;
   sel_t                   sel_r;
   logic [AWIDTH:0]        wptr_r;
   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [INSTR_WIDTH-1:0] rd_data_r;
   logic                   fresh_r;
   logic                   xfer_s;
   logic                   serve_s;
   logic                   end_seen_s;
   logic [INSTR_WIDTH-1:0] instr_s;

   // Handshake qualification, output word selection and END_CHAIN detection.
   always_comb begin
      xfer_s  = load_valid && load_ready && !clear && !rst;
      serve_s = (state_r == ST_RUN) && get_instr;
      case (sel_r)
         SEL_RAM: instr_s = rd_data_r;
         SEL_NOP: instr_s = NOP_WORD;
         default: instr_s = {INSTR_WIDTH{1'b0}};
      endcase
      if (fresh_r && (state_r == ST_RUN)) begin
         end_seen_s = (instr_s[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_OP);
      end else begin
         end_seen_s = 1'b0;
      end
   end

   assign instruction = instr_s;

   // Block RAM write port.
   always_ff @(posedge clk) begin
      if (xfer_s) begin
         mem[wptr_r[AWIDTH-1:0]] <= load_data;
      end
   end

   // Block RAM registered read port; only served fetches update it.
   always_ff @(posedge clk) begin
      if (serve_s) begin
         rd_data_r <= mem[get_instr_addr];
      end
   end

   // Control FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         sel_r         <= SEL_ZERO;
         fresh_r       <= 1'b0;
         wptr_r        <= {(AWIDTH+1){1'b0}};
         prog_len      <= {(AWIDTH+1){1'b0}};
         load_overflow <= 1'b0;
         load_ready    <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef FEEDER_FETCH_COUNT_EN
         fetch_count   <= 16'd0;
`endif
      end else begin
         fresh_r <= serve_s;
         if (serve_s) begin
            sel_r <= ({1'b0, get_instr_addr} < prog_len) ? SEL_RAM : SEL_NOP;
`ifdef FEEDER_FETCH_COUNT_EN
            if (fetch_count != 16'hFFFF) begin
               fetch_count <= fetch_count + 16'd1;
            end
`endif
         end
         if (clear && (state_r != ST_RUN)) begin
            state_r       <= ST_IDLE;
            wptr_r        <= {(AWIDTH+1){1'b0}};
            prog_len      <= {(AWIDTH+1){1'b0}};
            load_overflow <= 1'b0;
            load_ready    <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef FEEDER_FETCH_COUNT_EN
            fetch_count   <= 16'd0;
`endif
         end else begin
            case (state_r)
               ST_IDLE, ST_LOAD: begin
                  if (xfer_s) begin
                     wptr_r <= wptr_r + ONE;
                     if (load_last) begin
                        prog_len   <= wptr_r + ONE;
                        load_ready <= 1'b0;
                        state_r    <= ST_READY;
                     end else if (wptr_r == LAST_PTR) begin
                        prog_len      <= FULL_LEN;
                        load_overflow <= 1'b1;
                        load_ready    <= 1'b0;
                        state_r       <= ST_READY;
                     end else begin
                        state_r <= ST_LOAD;
                     end
                  end else begin
                     state_r <= state_r;
                  end
               end
               ST_READY, ST_DONE: begin
                  if (start) begin
                     state_r <= ST_RUN;
                     busy    <= 1'b1;
                     done    <= 1'b0;
`ifdef FEEDER_FETCH_COUNT_EN
                     fetch_count <= 16'd0;
`endif
                  end else begin
                     state_r <= state_r;
                  end
               end
               ST_RUN: begin
                  if (end_seen_s) begin
                     state_r <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
               default: begin
                  state_r    <= ST_IDLE;
                  load_ready <= 1'b1;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_npu_instr_feeder.sv
// Directed self-checking bench for npu_instr_feeder.
module tb_npu_instr_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [47:0] load_data = 48'd0;
   logic        load_last = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        get_instr = 1'b0;
   logic [9:0]  get_instr_addr = 10'd0;
   logic [47:0] instruction;
   logic        busy;
   logic        done;
   logic [10:0] prog_len;
   logic        load_overflow;
`ifdef FEEDER_FETCH_COUNT_EN
   logic [15:0] fetch_count;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [47:0] W0  = 48'h1000_0000_0001;
   localparam logic [47:0] W1  = 48'h4123_4567_89AB;
   localparam logic [47:0] W2  = 48'hC000_0000_0000;
   localparam logic [47:0] NOP = 48'hC000_0000_0000;

   npu_instr_feeder dut (
`ifdef FEEDER_FETCH_COUNT_EN
      .fetch_count(fetch_count),
`endif
      .clk(clk),
      .rst(rst),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data(load_data),
      .load_last(load_last),
      .clear(clear),
      .start(start),
      .get_instr(get_instr),
      .get_instr_addr(get_instr_addr),
      .instruction(instruction),
      .busy(busy),
      .done(done),
      .prog_len(prog_len),
      .load_overflow(load_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [47:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch(input logic [9:0] a);
      get_instr      = 1'b1;
      get_instr_addr = a;
      tick();
      get_instr      = 1'b0;
   endtask

   initial begin
      tick();
      rst = 1'b0;
      check("rst_load_ready", 64'(load_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_prog_len", 64'(prog_len), 64'd0);
      check("rst_overflow", 64'(load_overflow), 64'd0);
      check("rst_instr", 64'(instruction), 64'd0);

      // 3-word program, back-to-back fetches
      load_word(W0, 1'b0);
      load_word(W1, 1'b0);
      load_word(W2, 1'b1);
      check("p3_prog_len", 64'(prog_len), 64'd3);
      check("p3_ready_low", 64'(load_ready), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("p3_busy", 64'(busy), 64'd1);
      get_instr = 1'b1;
      get_instr_addr = 10'd0;
      tick();
      check("p3_w0", 64'(instruction), 64'(W0));
      get_instr_addr = 10'd1;
      tick();
      check("p3_w1", 64'(instruction), 64'(W1));
      get_instr_addr = 10'd2;
      tick();
      get_instr = 1'b0;
      check("p3_w2", 64'(instruction), 64'(W2));
      check("p3_done_not_yet", 64'(done), 64'd0);
      tick();
      check("p3_done", 64'(done), 64'd1);
      check("p3_busy_low", 64'(busy), 64'd0);
`ifdef FEEDER_FETCH_COUNT_EN
      check("p3_fetch_count", 64'(fetch_count), 64'd3);
`endif

      // get_instr outside RUN is ignored
      fetch(10'd0);
      check("done_hold_instr", 64'(instruction), 64'(W2));

      // out-of-range fetch returns NOP and completes
      start = 1'b1;
      tick();
      start = 1'b0;
      check("oor_busy", 64'(busy), 64'd1);
      check("oor_done_cleared", 64'(done), 64'd0);
      fetch(10'd5);
      check("oor_nop", 64'(instruction), 64'(NOP));
      tick();
      check("oor_done", 64'(done), 64'd1);

      // start and clear together from DONE: clear wins
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      check("sc_busy", 64'(busy), 64'd0);
      check("sc_done", 64'(done), 64'd0);
      check("sc_load_ready", 64'(load_ready), 64'd1);
      check("sc_prog_len", 64'(prog_len), 64'd0);
`ifdef FEEDER_FETCH_COUNT_EN
      check("sc_fetch_count", 64'(fetch_count), 64'd0);
`endif

      // clear drops a same-cycle load transfer
      load_word(W0, 1'b0);
      load_valid = 1'b1;
      load_last  = 1'b1;
      load_data  = W1;
      clear      = 1'b1;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      clear      = 1'b0;
      check("clr_load_prog_len", 64'(prog_len), 64'd0);
      check("clr_load_ready", 64'(load_ready), 64'd1);

      // 1-word program, get_instr in READY ignored
      load_word(W1, 1'b1);
      check("p1_prog_len", 64'(prog_len), 64'd1);
      fetch(10'd0);
      check("ready_instr_hold", 64'(instruction), 64'(NOP));
      check("ready_done_low", 64'(done), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(10'd0);
      check("p1_w", 64'(instruction), 64'(W1));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("run_clear_busy", 64'(busy), 64'd1);
      check("run_clear_len", 64'(prog_len), 64'd1);

      // reset mid-run, then reset mid-load
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_busy", 64'(busy), 64'd0);
      check("rr_instr", 64'(instruction), 64'd0);
      load_word(48'h0000_0000_00AA, 1'b0);
      load_word(48'h0000_0000_00BB, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rl_prog_len", 64'(prog_len), 64'd0);
      check("rl_load_ready", 64'(load_ready), 64'd1);
      load_word(48'h0000_0000_0011, 1'b0);
      load_word(48'h0000_0000_0022, 1'b1);
      check("rl_reload_len", 64'(prog_len), 64'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(10'd1);
      check("rl_w1", 64'(instruction), 64'h0000_0000_0022);

      // overflow: 1024 words with no load_last
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load_valid = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         load_data = 48'(i) + 48'h0000_0100_0000;
         tick();
      end
      check("ov_flag", 64'(load_overflow), 64'd1);
      check("ov_prog_len", 64'(prog_len), 64'd1024);
      check("ov_ready_low", 64'(load_ready), 64'd0);
      load_data = 48'h0000_0000_0BAD;
      tick();
      load_valid = 1'b0;
      check("ov_refused_len", 64'(prog_len), 64'd1024);
      check("ov_refused_ready", 64'(load_ready), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(10'd1023);
      check("ov_last_word", 64'(instruction), 64'h0000_0100_03FF);
      fetch(10'd0);
      check("ov_first_word", 64'(instruction), 64'h0000_0100_0000);
      check("ov_not_done", 64'(done), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/npu_instr_feeder.md
Name: npu_instr_feeder

Overview:
- Instruction-memory front end that sits directly upstream of the NPU.
- Accepts a program over a simple valid/ready load port and stores it in an on-chip instruction RAM.
- Once started, answers the NPU's get_instr/get_instr_addr fetch requests by driving the 48-bit instruction bus.
- Flags completion when an END_CHAIN opcode has been delivered.

Parameters:
- INSTR_WIDTH, 48: instruction word width (opcode 4 + target 7 + dram addr 10 + target 7 + vrf addr 10 + vrf addr 10).
- AWIDTH, 10: instruction memory address width, matching the NPU get_instr_addr width.
- DEPTH, 1024: number of instruction words; must equal 2**AWIDTH.
- OPCODE_WIDTH, 4: opcode field width; the opcode is instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH].
- END_OPCODE, 12: END_CHAIN opcode value.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous, active-high.
- load_valid, input, 1: load word valid.
- load_ready, output, 1: feeder can accept a load word.
- load_data, input, INSTR_WIDTH: program word.
- load_last, input, 1: marks the final program word; qualified by load_valid.
- clear, input, 1: discard the loaded program and return to IDLE.
- start, input, 1: begin a run (one-cycle pulse).
- get_instr, input, 1: NPU fetch request.
- get_instr_addr, input, AWIDTH: NPU fetch address.
- instruction, output, INSTR_WIDTH: instruction word to the NPU.
- busy, output, 1: high in RUN.
- done, output, 1: END_CHAIN delivered; level signal.
- prog_len, output, AWIDTH+1: number of loaded words.
- load_overflow, output, 1: program was truncated at DEPTH words.

Behaviour:
- Reset values:
  - state = IDLE.
  - instruction = 0, load_ready = 1, busy = 0, done = 0, prog_len = 0, load_overflow = 0, write pointer = 0.
  - RAM contents are not cleared.
- States: IDLE, LOAD, READY, RUN, DONE.
- NOP word: {END_OPCODE, zeros}.
- Load:
  - A word transfers when load_valid && load_ready.
  - load_ready = 1 in IDLE and LOAD only.
  - The first transfer moves IDLE to LOAD.
  - Each transfer writes RAM[wptr] and increments wptr.
  - Transfer with load_last: prog_len = wptr+1, go to READY.
  - Transfer at wptr = DEPTH-1 without load_last: prog_len = DEPTH, load_overflow = 1, go to READY. Further load words are refused (load_ready = 0).
  - A load_last transfer in IDLE gives a 1-word program.
- start:
  - From READY or DONE: go to RUN, done <= 0.
  - Ignored in IDLE and LOAD.
- Fetch in RUN (read latency 1):
  - get_instr sampled high in cycle N: instruction is valid in cycle N+1 and holds until the next served request.
  - get_instr_addr < prog_len: drive RAM[addr].
  - get_instr_addr >= prog_len: drive the NOP word.
  - Back-to-back requests are supported, one per cycle.
- Completion:
  - If the word driven in cycle N+1 has opcode END_OPCODE (RAM word or out-of-range NOP), go to DONE in that same cycle. done = 1 and busy = 0 from cycle N+2.
- get_instr outside RUN: ignored; instruction holds.
- clear:
  - Allowed in any state except RUN, where it is ignored.
  - Returns to IDLE with prog_len = 0, wptr = 0, load_overflow = 0, done = 0.
  - clear has priority over a same-cycle load transfer, which is dropped (load_ready is treated as 0 that cycle).
- start together with clear: clear wins.
- Reset mid-load or mid-run: returns to the reset state. Partially written RAM is kept but unreachable because prog_len = 0.
- The RAM must infer a single block RAM: one write port used in LOAD, one registered read port.

Optional Feature:
- Macro: FEEDER_FETCH_COUNT_EN.
- When defined, add output fetch_count [15:0]:
  - Counts served fetches in RUN.
  - Cleared on rst, clear, and each accepted start.
  - Saturates at 16'hFFFF.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load 3 words {0x1000_0000_0001, 0x4123_4567_89AB, 0xC000_0000_0000} with load_last on the 3rd, start, fetch addrs 0,1,2 back-to-back:
  - instruction equals each word one cycle after its request.
  - prog_len = 3.
  - done = 1 two cycles after the addr-2 request; busy = 0.
- Same program, fetch addr 5:
  - instruction = 0xC000_0000_0000 (NOP); done is set.
- Load 1024 words with no load_last:
  - load_overflow = 1, prog_len = 1024, load_ready = 0.
  - A 1025th load_valid is refused.
- Assert get_instr in READY:
  - instruction unchanged, done stays 0.
  - Then start, fetch addr 0: correct word returned.
- rst asserted after 2 of 4 load words:
  - prog_len = 0, state IDLE, load_ready = 1.
  - Reload of 2 words with load_last gives prog_len = 2.
- From DONE assert start and clear in the same cycle: state IDLE, done = 0. With FEEDER_FETCH_COUNT_EN, fetch_count = 0.
